// File: rtl/apb_mem_slave_if.sv
// ---------------------------------------------------------------------------
// apb_mem_slave_if
//   Bundles the APB completer signals and the single-port memory strobes of
//   apb_mem_slave into one interface.
//   slave  modport : the completer (drives PRDATA/PREADY/PSLVERR and memory
//                    strobes, samples APB request and memory read data)
//   master modport : the APB requester plus the memory model (drives the APB
//                    request and memory read data, samples the rest)
//   Signals
//     i_psel, i_penable, i_pwrite   APB select / access phase / direction
//     i_paddr [PADDR_WIDTH]         APB byte address
//     i_pwdata [DATA_WIDTH]         APB write data
//     o_prdata [DATA_WIDTH]         APB read data
//     o_pready, o_pslverr           APB completion / error
//     o_mem_en, o_mem_wr            memory enable pulse / write select
//     o_mem_addr [ADDR_WIDTH]       memory word address
//     o_mem_data_w [DATA_WIDTH]     memory write data
//     i_mem_data_r [DATA_WIDTH]     memory read data (1-cycle latency)
// ---------------------------------------------------------------------------
interface apb_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned PADDR_WIDTH = 32
);
    logic                   i_psel;
    logic                   i_penable;
    logic                   i_pwrite;
    logic [PADDR_WIDTH-1:0] i_paddr;
    logic [DATA_WIDTH-1:0]  i_pwdata;
    logic [DATA_WIDTH-1:0]  o_prdata;
    logic                   o_pready;
    logic                   o_pslverr;
    logic                   o_mem_en;
    logic                   o_mem_wr;
    logic [ADDR_WIDTH-1:0]  o_mem_addr;
    logic [DATA_WIDTH-1:0]  o_mem_data_w;
    logic [DATA_WIDTH-1:0]  i_mem_data_r;

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_mem_data_r,
        output o_prdata, o_pready, o_pslverr,
        output o_mem_en, o_mem_wr, o_mem_addr, o_mem_data_w
    );

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_mem_data_r,
        input  o_prdata, o_pready, o_pslverr,
        input  o_mem_en, o_mem_wr, o_mem_addr, o_mem_data_w
    );
endinterface

// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//   APB3 completer in front of a synchronous single-port memory with a
//   registered 1-cycle read. Each APB transfer becomes exactly one memory
//   enable pulse (after WAIT_STATES optional wait cycles); reads wait out the
//   memory latency before PREADY. Addresses below BASE_ADDR, misaligned to the
//   data word, or beyond the memory window complete with PSLVERR and never
//   touch the memory.
//   Ports
//     i_clk   clock, rising edge
//     i_rst   asynchronous active-high reset
//     bus     apb_mem_slave_if.slave (APB request/response + memory strobes)
//   Parameters
//     ADDR_WIDTH   memory word-address width (depth 2^ADDR_WIDTH)
//     DATA_WIDTH   data width, multiple of 8 and a power of two
//     PADDR_WIDTH  APB byte-address width (>= ADDR_WIDTH + log2(DATA_WIDTH/8))
//     BASE_ADDR    byte address of memory word 0, word aligned
//     WAIT_STATES  extra cycles before each memory access (0..15)
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            DATA_WIDTH  = 16,
    parameter int unsigned            PADDR_WIDTH = 32,
    parameter logic [PADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned            WAIT_STATES = 0
) (
    input logic           i_clk,
    input logic           i_rst,
    apb_mem_slave_if.slave bus
);

    // Byte-lane bits of the APB address that select within one data word.
    localparam int unsigned            ALIGN      = $clog2(DATA_WIDTH / 8);
    localparam logic [PADDR_WIDTH-1:0] ALIGN_MASK = PADDR_WIDTH'((1 << ALIGN) - 1);
    localparam logic [3:0]             WS_LOAD    = 4'(WAIT_STATES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_MEM    = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // -----------------------------------------------------------------------
    // Address decode (only meaningful in the setup cycle)
    // -----------------------------------------------------------------------
    logic [PADDR_WIDTH-1:0] dec_off;
    logic [PADDR_WIDTH-1:0] dec_word_full;
    logic [ADDR_WIDTH-1:0]  dec_word;
    logic                   dec_below;
    logic                   dec_misal;
    logic                   dec_oow;
    logic                   dec_err;

    assign dec_off       = bus.i_paddr - BASE_ADDR;
    assign dec_word_full = dec_off >> ALIGN;
    assign dec_word      = dec_word_full[ADDR_WIDTH-1:0];
    // Offset wraps when paddr < BASE_ADDR, so the compare has to be explicit.
    assign dec_below     = bus.i_paddr < BASE_ADDR;
    assign dec_misal     = (dec_off & ALIGN_MASK) != '0;
    // Any word-index bit above the window means the access misses the memory.
    assign dec_oow       = (dec_word_full >> ADDR_WIDTH) != '0;
    assign dec_err       = dec_below | dec_misal | dec_oow;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]            state_q,      state_d;
    logic [3:0]            cnt_q,        cnt_d;
    logic                  wr_q,         wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic                  err_q,        err_d;
    logic [DATA_WIDTH-1:0] prdata_q,     prdata_d;
    logic                  pready_q,     pready_d;
    logic                  pslverr_q,    pslverr_d;
    logic                  mem_en_q,     mem_en_d;
    logic                  mem_wr_q,     mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        prdata_d    = prdata_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                // Only a genuine setup phase starts a transfer; an access
                // phase with no preceding setup is ignored.
                if (bus.i_psel && !bus.i_penable) begin
                    wr_d    = bus.i_pwrite;
                    addr_d  = dec_word;
                    wdata_d = bus.i_pwdata;
                    err_d   = dec_err;
                    cnt_d   = WS_LOAD;
                    if (dec_err)
                        state_d = S_RESP;
                    else if (WAIT_STATES != 0)
                        state_d = S_WAIT;
                    else
                        state_d = S_MEM;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!bus.i_psel)
                    state_d = S_IDLE;
                else if (cnt_q == 4'd1)
                    state_d = err_q ? S_RESP : S_MEM;
            end

            S_MEM: begin
                // The memory already sees this cycle's enable; an abort here
                // cannot cancel a write.
                if (!bus.i_psel)
                    state_d = S_IDLE;
                else
                    state_d = wr_q ? S_RESP : S_RDWAIT;
            end

            S_RDWAIT: begin
                if (!bus.i_psel) begin
                    state_d = S_IDLE;
                end else begin
                    prdata_d = bus.i_mem_data_r;
                    state_d  = S_RESP;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are loaded on entry to the state
        // that presents them. Memory strobes come from the *_d copies because
        // a zero-wait transfer enters MEM in the same edge it latches fields.
        if (state_d == S_MEM) begin
            mem_en_d    = 1'b1;
            mem_wr_d    = wr_d;
            mem_addr_d  = addr_d;
            mem_wdata_d = wdata_d;
        end

        if (state_d == S_RESP) begin
            pready_d  = 1'b1;
            pslverr_d = err_d;
            if (err_d && !wr_d)
                prdata_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.o_prdata     = prdata_q;
    assign bus.o_pready     = pready_q;
    assign bus.o_pslverr    = pslverr_q;
    assign bus.o_mem_en     = mem_en_q;
    assign bus.o_mem_wr     = mem_wr_q;
    assign bus.o_mem_addr   = mem_addr_q;
    assign bus.o_mem_data_w = mem_wdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//   Two completers share one APB driver and one memory model: dut_a
//   (BASE 0, no wait states) and dut_b (BASE 0x100, 3 wait states). Only the
//   instance selected by `cur` sees PSEL. Expected responses and memory
//   accesses are pushed when a transfer is issued; a negedge monitor pops
//   and compares whenever PREADY or MEM_EN appears.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;
    localparam int          AW = 16;
    localparam int          DW = 16;
    localparam int          PAW = 32;
    localparam logic [31:0] BASE_A = 32'h0;
    localparam int          WS_A = 0;
    localparam logic [31:0] BASE_B = 32'h100;
    localparam int          WS_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PAW)) ifa ();
    apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PAW)) ifb ();

    apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PAW),
                    .BASE_ADDR(BASE_A), .WAIT_STATES(WS_A))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    apb_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PADDR_WIDTH(PAW),
                    .BASE_ADDR(BASE_B), .WAIT_STATES(WS_B))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    // APB driver signals
    logic           psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [PAW-1:0] paddr = '0;
    logic [DW-1:0]  pwdata = '0;
    bit             cur = 1'b0;

    logic [DW-1:0]  mem_rd = '0;

    assign ifa.i_psel = psel && !cur;
    assign ifb.i_psel = psel && cur;
    assign ifa.i_penable = penable;   assign ifb.i_penable = penable;
    assign ifa.i_pwrite  = pwrite;    assign ifb.i_pwrite  = pwrite;
    assign ifa.i_paddr   = paddr;     assign ifb.i_paddr   = paddr;
    assign ifa.i_pwdata  = pwdata;    assign ifb.i_pwdata  = pwdata;
    assign ifa.i_mem_data_r = mem_rd; assign ifb.i_mem_data_r = mem_rd;

    // Observed outputs of the active instance
    logic          m_en, m_wr, m_pready, m_pslverr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dw, m_prdata;
    assign m_en      = cur ? ifb.o_mem_en     : ifa.o_mem_en;
    assign m_wr      = cur ? ifb.o_mem_wr     : ifa.o_mem_wr;
    assign m_addr    = cur ? ifb.o_mem_addr   : ifa.o_mem_addr;
    assign m_dw      = cur ? ifb.o_mem_data_w : ifa.o_mem_data_w;
    assign m_pready  = cur ? ifb.o_pready     : ifa.o_pready;
    assign m_pslverr = cur ? ifb.o_pslverr    : ifa.o_pslverr;
    assign m_prdata  = cur ? ifb.o_prdata     : ifa.o_prdata;

    // Synchronous single-port memory, registered read, unwritten words read 0
    logic [DW-1:0] tbmem [int];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_wr) tbmem[int'(m_addr)] = m_dw;
            else      mem_rd <= tbmem.exists(int'(m_addr)) ? tbmem[int'(m_addr)] : '0;
        end
    end

    // Scoreboard
    typedef struct {
        int            due;
        logic          err;
        logic          chk_rd;
        logic [DW-1:0] rd;
    } resp_t;
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } macc_t;
    resp_t rq[$];
    macc_t mq[$];
    logic [DW-1:0] ref_mem [int];

    int vecs = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: address rules in plain arithmetic on byte addresses.
    function automatic void model(input logic [PAW-1:0] a, input longint base, input int ws,
                                  input logic wr, output bit err, output int word, output int lat);
        longint off;
        err = 1'b0;
        word = 0;
        if (longint'(a) < base) begin
            err = 1'b1;
        end else begin
            off = longint'(a) - base;
            if (off % 2 != 0)          err = 1'b1;
            else if (off / 2 >= 65536) err = 1'b1;
            else                       word = int'(off / 2);
        end
        lat = err ? 1 : (2 + ws + (wr ? 0 : 1));
    endfunction

    resp_t re;
    macc_t me;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_pready) begin
                if (rq.size() == 0) begin
                    check("unexpected_pready", 1, 0);
                end else begin
                    re = rq.pop_front();
                    check("pready_cycle", 64'(cyc), 64'(re.due));
                    check("pslverr", m_pslverr, re.err);
                    if (re.chk_rd) check("prdata", m_prdata, re.rd);
                end
            end else if (m_pslverr) begin
                check("pslverr_without_pready", 1, 0);
            end
            if (m_en) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_en", 1, 0);
                end else begin
                    me = mq.pop_front();
                    check("mem_wr", m_wr, me.wr);
                    check("mem_addr", m_addr, me.addr);
                    if (me.wr) check("mem_data_w", m_dw, me.data);
                end
            end
        end
    end

    // One APB transfer; called 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [PAW-1:0] a, input logic [DW-1:0] d,
                        input bit idle_after);
        resp_t r;
        macc_t m;
        bit    err;
        int    word, lat, n;
        model(a, cur ? longint'(BASE_B) : longint'(BASE_A), cur ? WS_B : WS_A, wr, err, word, lat);
        r.due = cyc + lat;
        r.err = err;
        r.chk_rd = !wr;
        r.rd = '0;
        if (!err) begin
            m.wr = wr; m.addr = AW'(word); m.data = d;
            mq.push_back(m);
            if (wr) ref_mem[word] = d;
            else    r.rd = ref_mem.exists(word) ? ref_mem[word] : '0;
        end
        rq.push_back(r);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        // Completer must have captured address/data at setup.
        paddr = $urandom; pwdata = DW'($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_pready && n < 32);
        if (!m_pready) check("pready_timeout", 0, 1);
        @(posedge clk); #1;
        if (idle_after) begin
            psel = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [PAW-1:0] rand_addr(input logic [PAW-1:0] base);
        case ($urandom_range(0, 5))
            0, 1, 2: return base + PAW'(2 * $urandom_range(0, 15));
            3:       return base + PAW'(2 * $urandom_range(65520, 65535));
            4:       return base + PAW'(2 * $urandom_range(0, 15) + 1);
            default: return PAW'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {ifa.o_pready, ifa.o_pslverr, ifa.o_prdata, ifa.o_mem_en,
                          ifa.o_mem_wr, ifa.o_mem_addr, ifa.o_mem_data_w}, 0);
        check("reset_b", {ifb.o_pready, ifb.o_pslverr, ifb.o_prdata, ifb.o_mem_en,
                          ifb.o_mem_wr, ifb.o_mem_addr, ifb.o_mem_data_w}, 0);
        rst = 1'b0;
        idle(2);

        // ---- instance A: BASE 0, no wait states
        xfer(1'b1, 32'h0004, 16'hBEEF, 1'b1);
        xfer(1'b0, 32'h0004, 16'h0000, 1'b1);

        // Reset while a read sits in MEM
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0004;
        @(posedge clk); #1;
        penable = 1'b1;
        check("rst_pre_mem_en", m_en, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_mem_en", m_en, 0);
        check("rst_mid_pready", m_pready, 0);
        check("rst_mid_prdata", m_prdata, 0);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        idle(2);
        xfer(1'b0, 32'h0004, 16'h0000, 1'b1);

        // Error transfers
        xfer(1'b0, 32'h0003, 16'h0000, 1'b1);
        xfer(1'b0, 32'h0002_0000, 16'h0000, 1'b1);
        xfer(1'b1, 32'h0002_0001, 16'h1111, 1'b1);

        // Access phase with no setup: ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0008;
        repeat (3) begin @(posedge clk); #1; end
        idle(3);

        // Abort in MEM with a write: memory still written
        begin
            macc_t m;
            m.wr = 1'b1; m.addr = 16'h0020; m.data = 16'h5A5A;
            mq.push_back(m);
            ref_mem[32'h20] = 16'h5A5A;
        end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0040; pwdata = 16'h5A5A;
        @(posedge clk); #1;
        idle(4);
        xfer(1'b0, 32'h0040, 16'h0000, 1'b1);

        // Back-to-back write/read pairs, last one at the top word
        for (int i = 0; i < 8; i++) begin
            logic [PAW-1:0] a;
            a = (i == 7) ? 32'h0001_FFFE : PAW'(2 * i);
            xfer(1'b1, a, DW'(16'hA000 + i * 16'h0111), 1'b0);
            xfer(1'b0, a, 16'h0000, i == 7);
        end

        for (int i = 0; i < 60; i++)
            xfer(1'($urandom_range(0, 1)), rand_addr(BASE_A), DW'($urandom), 1'($urandom_range(0, 1)));
        idle(3);

        // ---- instance B: BASE 0x100, 3 wait states
        cur = 1'b1;
        idle(2);
        xfer(1'b1, 32'h0110, 16'h1234, 1'b1);
        xfer(1'b0, 32'h0110, 16'h0000, 1'b1);
        xfer(1'b0, 32'h00FE, 16'h0000, 1'b1);
        xfer(1'b1, 32'h0111, 16'h7777, 1'b1);

        // Abort during WAIT: no memory access, no response
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0120; pwdata = 16'hDEAD;
        @(posedge clk); #1;
        psel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_wait_quiet", {m_en, m_pready}, 0);
        end
        @(posedge clk); #1;
        xfer(1'b0, 32'h0120, 16'h0000, 1'b1);

        for (int i = 0; i < 40; i++)
            xfer(1'($urandom_range(0, 1)), rand_addr(BASE_B), DW'($urandom), 1'($urandom_range(0, 1)));
        idle(5);

        check("resp_queue_drained", rq.size(), 0);
        check("mem_queue_drained", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
